// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared slot constants and types for the TDM demux/framer pair
package tdm_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } tdm_state_e;

    typedef logic [SLOT_W-1:0] slot_idx_t;

    localparam slot_idx_t FIRST_SLOT = slot_idx_t'(0);
    localparam slot_idx_t LAST_SLOT  = slot_idx_t'(NUM_SLOTS - 1);

endpackage

// File: rtl/tdm_slot_ctr.sv
// rtl/tdm_slot_ctr.sv - 3-bit slot counter with clear, load-to-1, increment and natural wrap
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr,
    input  logic      load1,
    input  logic      inc,
    output slot_idx_t count
);

    // Clear wins over load, load wins over increment; 7 + 1 wraps to 0 by width.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= FIRST_SLOT;
        end else if (load1) begin
            count <= slot_idx_t'(1);
        end else if (inc) begin
            count <= count + slot_idx_t'(1);
        end
    end

endmodule

// File: rtl/tdm_demux8.sv
// rtl/tdm_demux8.sv - 8-slot TDM demultiplexer; stats counters under TDM_DEMUX8_STATS_EN
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [WIDTH-1:0]           in_data,
    output logic [SLOT_W-1:0]          slot_idx,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_SLOTS*WIDTH-1:0] out_data,
    output logic                       sync_err,
    output logic                       overrun,
    output logic [15:0]                frame_cnt,
    output logic [15:0]                err_cnt
);

    tdm_state_e state;
    logic [WIDTH-1:0] coll_buf [NUM_SLOTS];

    logic hunt_start;
    logic resync;
    logic miss_sof;
    logic normal;
    logic frame_done;
    logic handoff;
    logic consume;
    logic [NUM_SLOTS*WIDTH-1:0] next_frame;

    // Classify the incoming slot against the current framing position.
    always_comb begin
        hunt_start = in_valid && (state == HUNT) && in_sof;
        resync     = in_valid && (state == COLLECT) && in_sof && (slot_idx != FIRST_SLOT);
        miss_sof   = in_valid && (state == COLLECT) && !in_sof && (slot_idx == FIRST_SLOT);
        normal     = in_valid && (state == COLLECT) && !resync && !miss_sof;
        frame_done = normal && (slot_idx == LAST_SLOT);
        handoff    = frame_done && (!out_valid || out_ready);
        consume    = out_valid && out_ready && !handoff;
    end

    // Assemble the outgoing frame: buffered slots 0..6 plus the slot arriving now.
    always_comb begin
        next_frame = '0;
        for (int k = 0; k < NUM_SLOTS - 1; k++) begin
            next_frame[k*WIDTH +: WIDTH] = coll_buf[k];
        end
        next_frame[(NUM_SLOTS-1)*WIDTH +: WIDTH] = in_data;
    end

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (miss_sof),
        .load1 (hunt_start || resync),
        .inc   (normal),
        .count (slot_idx)
    );

    // Framing state: a missing SOF drops back to HUNT, a mid-frame SOF resyncs in place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HUNT;
        end else if (hunt_start) begin
            state <= COLLECT;
        end else if (miss_sof) begin
            state <= HUNT;
        end
    end

    // Collect buffer: a (re)started frame overwrites slot 0, later slots land at slot_idx.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                coll_buf[k] <= '0;
            end
        end else if (hunt_start || resync) begin
            coll_buf[0] <= in_data;
        end else if (normal) begin
            coll_buf[slot_idx] <= in_data;
        end
    end

    // Single output register; a completed frame refused by a full register is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (handoff) begin
            out_valid <= 1'b1;
            out_data  <= next_frame;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    // Error pulses, registered so they appear one cycle after the offending slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_err <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            sync_err <= resync || miss_sof;
            overrun  <= frame_done && !handoff;
        end
    end

`ifdef TDM_DEMUX8_STATS_EN
    // Saturating frame and error counters; simultaneous errors count once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (handoff && (frame_cnt != 16'hFFFF)) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if ((resync || miss_sof || (frame_done && !handoff)) && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`else
    assign frame_cnt = 16'h0000;
    assign err_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// tb/tb_tdm_demux8.sv - table, directed and randomized checks for tdm_demux8
module tb_tdm_demux8;

    localparam int W = 8;
`ifdef TDM_DEMUX8_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_sof;
    logic [W-1:0]   in_data;
    logic [2:0]     slot_idx;
    logic           out_valid;
    logic           out_ready;
    logic [8*W-1:0] out_data;
    logic           sync_err;
    logic           overrun;
    logic [15:0]    frame_cnt;
    logic [15:0]    err_cnt;

    always #5 clk = ~clk;

    tdm_demux8 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .slot_idx  (slot_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sync_err  (sync_err),
        .overrun   (overrun),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;
    int se_seen = 0;
    int or_seen = 0;

    // Reference model: position within the frame, slots gathered so far, held output.
    bit          m_in_frame;
    int          m_pos;
    logic [W-1:0] m_slots [8];
    bit          m_ov;
    logic [63:0] m_od;
    bit          m_se;
    bit          m_or;
    int          m_fc;
    int          m_ec;

    function automatic void model_reset();
        m_in_frame = 0;
        m_pos = 0;
        for (int k = 0; k < 8; k++) m_slots[k] = '0;
        m_ov = 0; m_od = '0; m_se = 0; m_or = 0; m_fc = 0; m_ec = 0;
    endfunction

    function automatic void model_step(input bit v, input bit sof, input logic [W-1:0] d, input bit rdy);
        bit done = 0;
        m_se = 0;
        m_or = 0;
        if (v) begin
            if (!m_in_frame) begin
                if (sof) begin
                    m_slots[0] = d; m_pos = 1; m_in_frame = 1;
                end
            end else if (sof && m_pos != 0) begin
                m_se = 1; m_slots[0] = d; m_pos = 1;
            end else if (!sof && m_pos == 0) begin
                m_se = 1; m_in_frame = 0;
            end else begin
                m_slots[m_pos] = d;
                m_pos = m_pos + 1;
                if (m_pos == 8) begin
                    m_pos = 0; done = 1;
                end
            end
        end
        if (done) begin
            if (!m_ov || rdy) begin
                for (int k = 0; k < 8; k++) m_od[k*8 +: 8] = m_slots[k];
                m_ov = 1;
                if (m_fc < 65535) m_fc++;
            end else begin
                m_or = 1;
            end
        end else if (m_ov && rdy) begin
            m_ov = 0;
        end
        if ((m_se || m_or) && m_ec < 65535) m_ec++;
    endfunction

    function automatic logic [63:0] frame_of(input logic [7:0] base);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = base + 8'(k);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit v, input bit sof, input logic [W-1:0] d, input bit rdy);
        @(negedge clk);
        rst_n = !rst; in_valid = v; in_sof = sof; in_data = d; out_ready = rdy;
        if (rst) model_reset();
        else model_step(v, sof, d, rdy);
        @(posedge clk);
        #1;
        check("slot_idx", 64'(slot_idx), 64'(m_pos));
        check("out_valid", 64'(out_valid), 64'(m_ov));
        check("out_data", out_data, m_od);
        check("sync_err", 64'(sync_err), 64'(m_se));
        check("overrun", 64'(overrun), 64'(m_or));
        check("frame_cnt", 64'(frame_cnt), STATS ? 64'(m_fc) : 64'd0);
        check("err_cnt", 64'(err_cnt), STATS ? 64'(m_ec) : 64'd0);
        if (sync_err) se_seen++;
        if (overrun) or_seen++;
    endtask

    task automatic send_frame(input logic [7:0] base, input bit rdy, input bit rdy_last);
        for (int k = 0; k < 8; k++) begin
            step(0, 1, k == 0, base + 8'(k), (k == 7) ? rdy_last : rdy);
        end
    endtask

    typedef struct {
        bit          v;
        bit          sof;
        logic [7:0]  d;
        bit          rdy;
        logic [2:0]  e_idx;
        bit          e_ov;
        bit          e_se;
        bit          chk_d;
        logic [63:0] e_d;
    } vec_t;

    vec_t tbl[12];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();

        // Vector table: hunt-ignore, then a clean frame carrying data k on slot k.
        tbl[0] = '{1'b1, 1'b0, 8'h55, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[1] = '{1'b1, 1'b0, 8'h66, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 64'h0};
        for (int k = 0; k < 8; k++) begin
            tbl[3+k] = '{1'b1, (k == 0), 8'(k), 1'b1, 3'((k + 1) % 8), (k == 7), 1'b0,
                         (k == 7), 64'h0706050403020100};
        end
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 64'h0706050403020100};

        step(1, 0, 0, 0, 0);
        check("reset_out_data", out_data, 64'h0);
        check("reset_out_valid", 64'(out_valid), 64'h0);

        for (int i = 0; i < 12; i++) begin
            step(0, tbl[i].v, tbl[i].sof, tbl[i].d, tbl[i].rdy);
            check($sformatf("tbl%0d_slot_idx", i), 64'(slot_idx), 64'(tbl[i].e_idx));
            check($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
            check($sformatf("tbl%0d_sync_err", i), 64'(sync_err), 64'(tbl[i].e_se));
            if (tbl[i].chk_d) check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_d);
        end
        check("tbl_frame_cnt", 64'(frame_cnt), STATS ? 64'd1 : 64'd0);

        // Mid-frame SOF at slot 5 restarts the frame with A0..A7.
        step(1, 0, 0, 0, 1);
        se_seen = 0;
        for (int k = 0; k < 5; k++) step(0, 1, k == 0, 8'h30 + 8'(k), 1);
        send_frame(8'hA0, 1, 1);
        check("resync_pulses", 64'(se_seen), 64'd1);
        check("resync_out_valid", 64'(out_valid), 64'd1);
        check("resync_out_data", out_data, 64'hA7A6A5A4A3A2A1A0);
        check("resync_err_cnt", 64'(err_cnt), STATS ? 64'd1 : 64'd0);

        // Two frames with out_ready low: second completion overruns, first frame held.
        step(1, 0, 0, 0, 0);
        or_seen = 0;
        send_frame(8'hB0, 0, 0);
        send_frame(8'hC0, 0, 0);
        check("ovr_pulses", 64'(or_seen), 64'd1);
        check("ovr_out_valid", 64'(out_valid), 64'd1);
        check("ovr_out_data", out_data, frame_of(8'hB0));

        // Completion coincides with consumption of the held frame: swap, no overrun.
        or_seen = 0;
        send_frame(8'hD0, 0, 1);
        check("swap_pulses", 64'(or_seen), 64'd0);
        check("swap_out_valid", 64'(out_valid), 64'd1);
        check("swap_out_data", out_data, frame_of(8'hD0));

        // Reset for one cycle at slot 4, then a clean frame.
        for (int k = 0; k < 4; k++) step(0, 1, k == 0, 8'hE0 + 8'(k), 0);
        step(1, 1, 0, 8'hE4, 0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_slot_idx", 64'(slot_idx), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        send_frame(8'hF0, 1, 1);
        check("post_rst_out_data", out_data, frame_of(8'hF0));
        check("post_rst_out_valid", 64'(out_valid), 64'd1);

        // Randomized traffic with occasional framing faults, stalls and resets.
        for (int i = 0; i < 3000; i++) begin
            bit v, sof, rdy, rst;
            v   = ($urandom_range(0, 9) != 0);
            sof = (m_pos == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 29) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 599) == 0);
            step(rst, v, sof, 8'($urandom), rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
